div_unit: RTL and testbench



---
 rtl/div_unit_if.sv | 21 ++
 rtl/div_unit.sv | 130 +++++++++++++
 tb/tb_div_unit.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/div_unit_if.sv
// Request/response bundle between the EX-stage pipeline (master) and the divide sequencer (slave).
interface div_unit_if;
    logic        START;
    logic [4:0]  ALU_OP;
    logic [31:0] DATA1;
    logic [31:0] DATA2;
    logic        FLUSH;
    logic        BUSY;
    logic        DONE;
    logic [31:0] RESULT;

    modport master (
        output START, ALU_OP, DATA1, DATA2, FLUSH,
        input  BUSY, DONE, RESULT
    );

    modport slave (
        input  START, ALU_OP, DATA1, DATA2, FLUSH,
        output BUSY, DONE, RESULT
    );
endinterface

// File: rtl/div_unit.sv
// RV32M DIV/DIVU/REM/REMU sequencer: 32-step restoring division plus RISC-V sign and corner-case handling.
module div_unit (
    input  logic      CLK,
    input  logic      RESET,
    div_unit_if.slave bus
);
    localparam logic [4:0] OP_DIV  = 5'b10001;
    localparam logic [4:0] OP_DIVU = 5'b10101;
    localparam logic [4:0] OP_REM  = 5'b11001;
    localparam logic [4:0] OP_REMU = 5'b11101;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    function automatic logic [31:0] negate(input logic [31:0] v);
        return ~v + 32'd1;
    endfunction

    function automatic logic [31:0] magnitude(input logic signed [31:0] v);
        return v[31] ? negate($unsigned(v)) : $unsigned(v);
    endfunction

    state_t      state;
    state_t      state_next;
    logic [4:0]  count;
    logic        done;
    logic [31:0] result;

    logic [32:0] rem;
    logic [31:0] quo;
    logic [31:0] divisor;
    logic        neg_q;
    logic        neg_r;
    logic        rem_sel;

    logic        op_valid;
    logic        is_unsigned;
    logic        is_rem;
    logic        div_zero;
    logic        overflow;
    logic        special;
    logic        accept;
    logic [32:0] rem_shift;
    logic [32:0] rem_sub;
    logic        rem_ge;
    logic [31:0] fix_value;

    always_comb begin
        op_valid    = (bus.ALU_OP == OP_DIV) || (bus.ALU_OP == OP_DIVU) ||
                      (bus.ALU_OP == OP_REM) || (bus.ALU_OP == OP_REMU);
        is_unsigned = bus.ALU_OP[2];
        is_rem      = bus.ALU_OP[3];
        div_zero    = (bus.DATA2 == 32'd0);
        overflow    = !is_unsigned && (bus.DATA1 == 32'h8000_0000) && (bus.DATA2 == 32'hFFFF_FFFF);
        special     = div_zero || overflow;
        accept      = (state == IDLE) && bus.START && op_valid && !bus.FLUSH;
    end

    // Next-state logic; RESET is applied in the state register
    always_comb begin
        state_next = state;
        if (bus.FLUSH) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_next = special ? FIX : CALC;
                CALC:    if (count == 5'd31) state_next = FIX;
                FIX:     state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Output decode: BUSY comes from the state register only
    always_comb begin
        bus.BUSY   = (state != IDLE);
        bus.DONE   = done;
        bus.RESULT = result;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state  <= IDLE;
            count  <= 5'd0;
            done   <= 1'b0;
            result <= 32'd0;
        end else begin
            state <= state_next;
            done  <= (state == FIX) && !bus.FLUSH;
            if ((state == FIX) && !bus.FLUSH)
                result <= fix_value;
            if (state != CALC || bus.FLUSH)
                count <= 5'd0;
            else
                count <= count + 5'd1;
        end
    end

    // One restoring step: shift in the next dividend bit, subtract when it fits
    always_comb begin
        rem_shift = {rem[31:0], quo[31]};
        rem_sub   = rem_shift - {1'b0, divisor};
        rem_ge    = (rem_shift >= {1'b0, divisor});
        if (rem_sel)
            fix_value = neg_r ? negate(rem[31:0]) : rem[31:0];
        else
            fix_value = neg_q ? negate(quo) : quo;
    end

    // Operand datapath carries no reset; it is always reloaded on acceptance
    always_ff @(posedge CLK) begin
        if (accept) begin
            rem_sel <= is_rem;
            divisor <= is_unsigned ? bus.DATA2 : magnitude($signed(bus.DATA2));
            if (special) begin
                neg_q <= 1'b0;
                neg_r <= 1'b0;
                quo   <= div_zero ? 32'hFFFF_FFFF : 32'h8000_0000;
                rem   <= div_zero ? {1'b0, bus.DATA1} : 33'd0;
            end else begin
                neg_q <= !is_unsigned && !is_rem && (bus.DATA1[31] ^ bus.DATA2[31]);
                neg_r <= !is_unsigned && is_rem && bus.DATA1[31];
                quo   <= is_unsigned ? bus.DATA1 : magnitude($signed(bus.DATA1));
                rem   <= 33'd0;
            end
        end else if (state == CALC) begin
            rem <= rem_ge ? rem_sub : rem_shift;
            quo <= {quo[30:0], rem_ge};
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// Directed self-checking bench for div_unit: arithmetic, corner cases, FLUSH/RESET aborts and handshake timing.
module tb_div_unit;
    logic CLK;
    logic RESET;
    int   n_cmp = 0;
    int   n_bad = 0;

    div_unit_if dif ();

    div_unit dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (dif)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Drive one request; returns 1 ns after the accepting edge T0 with inputs scrambled
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge CLK);
        dif.START  = 1'b1;
        dif.ALU_OP = op;
        dif.DATA1  = a;
        dif.DATA2  = b;
        @(posedge CLK);
        #1;
        dif.START  = 1'b0;
        dif.ALU_OP = 5'b10101;
        dif.DATA1  = 32'hDEAD_BEEF;
        dif.DATA2  = 32'h0000_0003;
    endtask

    // Counts edges until DONE is seen (1 ns after each edge); -1 if it never comes
    task automatic wait_done(output int lat);
        bit seen = 0;
        lat = 0;
        while (!seen && lat < 60) begin
            @(posedge CLK);
            #1;
            lat++;
            if (dif.DONE === 1'b1) seen = 1;
        end
        if (!seen) lat = -1;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (3) @(posedge CLK);
        #1;
        RESET = 1'b0;
        n_cmp++;
        if (dif.BUSY !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", dif.BUSY); end
        n_cmp++;
        if (dif.DONE !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", dif.DONE); end
        n_cmp++;
        if (dif.RESULT !== 32'd0) begin n_bad++; $display("FAIL reset_result: got %h want 0", dif.RESULT); end
    endtask

    task automatic test_arith();
        logic [4:0]  ops [8] = '{5'b10001, 5'b11001, 5'b10101, 5'b11101,
                                 5'b10001, 5'b11001, 5'b10001, 5'b11001};
        logic [31:0] as  [8] = '{32'd10, 32'd10, 32'hFFFF_FFF6, 32'hFFFF_FFF6,
                                 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'd7};
        logic [31:0] bs  [8] = '{32'd4, 32'd4, 32'd4, 32'd4,
                                 32'd2, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
        logic [31:0] exp [8] = '{32'd2, 32'd2, 32'h3FFF_FFFD, 32'd2,
                                 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd1};
        int lat;
        for (int i = 0; i < 8; i++) begin
            issue(ops[i], as[i], bs[i]);
            n_cmp++;
            if (dif.BUSY !== 1'b1) begin n_bad++; $display("FAIL arith_busy[%0d]: got %b want 1", i, dif.BUSY); end
            wait_done(lat);
            n_cmp++;
            if (lat != 33) begin n_bad++; $display("FAIL arith_latency[%0d]: got %0d want 33", i, lat); end
            n_cmp++;
            if (dif.RESULT !== exp[i]) begin n_bad++; $display("FAIL arith_result[%0d]: got %h want %h", i, dif.RESULT, exp[i]); end
            n_cmp++;
            if (dif.BUSY !== 1'b0) begin n_bad++; $display("FAIL arith_busy_at_done[%0d]: got %b want 0", i, dif.BUSY); end
            @(posedge CLK);
            #1;
            n_cmp++;
            if (dif.DONE !== 1'b0) begin n_bad++; $display("FAIL arith_done_pulse[%0d]: got %b want 0", i, dif.DONE); end
            n_cmp++;
            if (dif.RESULT !== exp[i]) begin n_bad++; $display("FAIL arith_result_hold[%0d]: got %h want %h", i, dif.RESULT, exp[i]); end
        end
    endtask

    task automatic test_special();
        logic [4:0]  ops [4] = '{5'b10001, 5'b11101, 5'b10001, 5'b11001};
        logic [31:0] as  [4] = '{32'd123, 32'd123, 32'h8000_0000, 32'h8000_0000};
        logic [31:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        logic [31:0] exp [4] = '{32'hFFFF_FFFF, 32'd123, 32'h8000_0000, 32'd0};
        int lat;
        for (int i = 0; i < 4; i++) begin
            issue(ops[i], as[i], bs[i]);
            n_cmp++;
            if (dif.BUSY !== 1'b1) begin n_bad++; $display("FAIL special_busy[%0d]: got %b want 1", i, dif.BUSY); end
            wait_done(lat);
            n_cmp++;
            if (lat != 1) begin n_bad++; $display("FAIL special_latency[%0d]: got %0d want 1", i, lat); end
            n_cmp++;
            if (dif.RESULT !== exp[i]) begin n_bad++; $display("FAIL special_result[%0d]: got %h want %h", i, dif.RESULT, exp[i]); end
            n_cmp++;
            if (dif.BUSY !== 1'b0) begin n_bad++; $display("FAIL special_busy_drop[%0d]: got %b want 0", i, dif.BUSY); end
        end
        issue(5'b10101, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat);
        n_cmp++;
        if (lat != 33) begin n_bad++; $display("FAIL divu_ovf_latency: got %0d want 33", lat); end
        n_cmp++;
        if (dif.RESULT !== 32'd0) begin n_bad++; $display("FAIL divu_ovf_result: got %h want 0", dif.RESULT); end
    endtask

    task automatic test_flush();
        int lat;
        bit seen = 0;
        logic [31:0] prev;
        issue(5'b11001, 32'd100, 32'd7);
        wait_done(lat);
        prev = dif.RESULT;
        issue(5'b10001, 32'd100, 32'd7);
        repeat (9) @(posedge CLK);
        #1;
        dif.FLUSH  = 1'b1;
        dif.START  = 1'b1;
        dif.ALU_OP = 5'b10001;
        @(posedge CLK);
        #1;
        dif.FLUSH = 1'b0;
        dif.START = 1'b0;
        n_cmp++;
        if (dif.BUSY !== 1'b0) begin n_bad++; $display("FAIL flush_busy: got %b want 0", dif.BUSY); end
        n_cmp++;
        if (dif.RESULT !== prev) begin n_bad++; $display("FAIL flush_result_hold: got %h want %h", dif.RESULT, prev); end
        for (int i = 0; i < 40; i++) begin
            @(posedge CLK);
            #1;
            if (dif.DONE === 1'b1) seen = 1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin n_bad++; $display("FAIL flush_no_done: got %b want 0", seen); end
        issue(5'b11001, 32'd100, 32'd7);
        wait_done(lat);
        n_cmp++;
        if (lat != 33) begin n_bad++; $display("FAIL after_flush_latency: got %0d want 33", lat); end
        n_cmp++;
        if (dif.RESULT !== 32'd2) begin n_bad++; $display("FAIL after_flush_result: got %h want 2", dif.RESULT); end
    endtask

    task automatic test_reset_mid();
        bit seen = 0;
        issue(5'b10001, 32'd100, 32'd7);
        repeat (4) @(posedge CLK);
        #1;
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        n_cmp++;
        if (dif.BUSY !== 1'b0) begin n_bad++; $display("FAIL midreset_busy: got %b want 0", dif.BUSY); end
        n_cmp++;
        if (dif.RESULT !== 32'd0) begin n_bad++; $display("FAIL midreset_result: got %h want 0", dif.RESULT); end
        for (int i = 0; i < 40; i++) begin
            @(posedge CLK);
            #1;
            if (dif.DONE === 1'b1) seen = 1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin n_bad++; $display("FAIL midreset_no_done: got %b want 0", seen); end
    endtask

    task automatic test_bad_op();
        bit seen = 0;
        issue(5'b00000, 32'd10, 32'd4);
        n_cmp++;
        if (dif.BUSY !== 1'b0) begin n_bad++; $display("FAIL badop_busy: got %b want 0", dif.BUSY); end
        for (int i = 0; i < 5; i++) begin
            @(posedge CLK);
            #1;
            if (dif.DONE === 1'b1) seen = 1;
        end
        n_cmp++;
        if (seen !== 1'b0) begin n_bad++; $display("FAIL badop_no_done: got %b want 0", seen); end
    endtask

    task automatic test_start_while_busy();
        int lat;
        issue(5'b10001, 32'd100, 32'd7);
        @(negedge CLK);
        dif.START  = 1'b1;
        dif.ALU_OP = 5'b11001;
        dif.DATA1  = 32'd55;
        dif.DATA2  = 32'd3;
        @(posedge CLK);
        #1;
        dif.START = 1'b0;
        wait_done(lat);
        n_cmp++;
        if (lat != 32) begin n_bad++; $display("FAIL busy_start_latency: got %0d want 32", lat); end
        n_cmp++;
        if (dif.RESULT !== 32'd14) begin n_bad++; $display("FAIL busy_start_result: got %h want 0000000e", dif.RESULT); end
    endtask

    task automatic test_back_to_back();
        int lat;
        issue(5'b10001, 32'd10, 32'd4);
        wait_done(lat);
        n_cmp++;
        if (dif.RESULT !== 32'd2) begin n_bad++; $display("FAIL b2b_first_result: got %h want 2", dif.RESULT); end
        issue(5'b10101, 32'hFFFF_FFF6, 32'd4);
        n_cmp++;
        if (dif.DONE !== 1'b0) begin n_bad++; $display("FAIL b2b_done_clear: got %b want 0", dif.DONE); end
        n_cmp++;
        if (dif.BUSY !== 1'b1) begin n_bad++; $display("FAIL b2b_accepted: got %b want 1", dif.BUSY); end
        wait_done(lat);
        n_cmp++;
        if (lat != 33) begin n_bad++; $display("FAIL b2b_latency: got %0d want 33", lat); end
        n_cmp++;
        if (dif.RESULT !== 32'h3FFF_FFFD) begin n_bad++; $display("FAIL b2b_second_result: got %h want 3ffffffd", dif.RESULT); end
    endtask

    initial begin
        RESET      = 1'b1;
        dif.START  = 1'b0;
        dif.FLUSH  = 1'b0;
        dif.ALU_OP = 5'd0;
        dif.DATA1  = 32'd0;
        dif.DATA2  = 32'd0;
        test_reset();
        test_arith();
        test_special();
        test_flush();
        test_reset_mid();
        test_bad_op();
        test_start_while_busy();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
